// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display: per-frame BCD snapshot,
// per-digit blanking gap, leading-zero blanking; optional digit blinking under SEG_SCAN_BLINK_EN.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      lzb_en,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [3:0]                digit_bcd,
  output logic [NUM_DIGITS-1:0]     digit_en_n,
  output logic                      frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t                    state, state_nx;
  logic [CNT_W-1:0]          cnt, cnt_nx;
  logic [IDX_W-1:0]          idx, idx_nx;
  logic [4*NUM_DIGITS-1:0]   shadow, shadow_nx;
  logic                      lzb_q, lzb_nx;
  logic                      snap, wrap;
  logic                      blink_off, blanked;
  logic [3:0]                bcd_nx;
  logic [NUM_DIGITS-1:0]     en_n_nx;

  // True when digit i is a zero above the most significant nonzero digit (digit 0 excluded).
  function automatic logic lead_zero(input logic [4*NUM_DIGITS-1:0] sh, input logic [IDX_W-1:0] i);
    logic z;
    z = (i != '0);
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(i) && sh[4*j +: 4] != 4'h0) z = 1'b0;
    return z;
  endfunction

  // NOTE: every signal gets a default before any branch so this block never infers a latch.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    shadow_nx = shadow;
    lzb_nx    = lzb_q;
    snap      = 1'b0;
    wrap      = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      if (state == IDLE) begin
        cnt_nx = '0;
        idx_nx = '0;
        snap   = 1'b1;
      end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
        cnt_nx = '0;
        if (idx == IDX_W'(NUM_DIGITS - 1)) begin
          idx_nx = '0;
          snap   = 1'b1;
          wrap   = 1'b1;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end else begin
        cnt_nx = cnt + 1'b1;
      end
      if (snap) begin
        shadow_nx = digits_in;
        lzb_nx    = lzb_en;
      end
      state_nx = (BLANK_CYCLES == 0 || cnt_nx >= CNT_W'(BLANK_CYCLES)) ? DRIVE : BLANK;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES) + 1;

  logic [NUM_DIGITS-1:0] mask_q, mask_nx;
  logic [FC_W-1:0]       fcnt, fcnt_nx;
  logic                  phase, phase_nx;

  // Frames are counted on completion, so frame k blinks when (k / BLINK_FRAMES) is odd.
  always_comb begin
    mask_nx  = mask_q;
    fcnt_nx  = fcnt;
    phase_nx = phase;
    if (snap) mask_nx = blink_mask;
    if (wrap) begin
      if (fcnt == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt_nx  = '0;
        phase_nx = ~phase;
      end else begin
        fcnt_nx = fcnt + 1'b1;
      end
    end
    blink_off = phase_nx & mask_nx[idx_nx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      fcnt   <= '0;
      phase  <= 1'b0;
    end else begin
      mask_q <= mask_nx;
      fcnt   <= fcnt_nx;
      phase  <= phase_nx;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_off    = 1'b0;
`endif

  // Outputs are computed from the next state so they line up with the registered state.
  always_comb begin
    blanked = (lzb_nx & lead_zero(shadow_nx, idx_nx)) | blink_off;
    bcd_nx  = 4'hF;
    en_n_nx = '1;
    if (state_nx != IDLE && !blanked) begin
      bcd_nx = shadow_nx[4*idx_nx +: 4];
      if (state_nx == DRIVE) en_n_nx[idx_nx] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      lzb_q       <= 1'b0;
      digit_bcd   <= 4'hF;
      digit_en_n  <= '1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      shadow      <= shadow_nx;
      lzb_q       <= lzb_nx;
      digit_bcd   <= bcd_nx;
      digit_en_n  <= en_n_nx;
      frame_start <= snap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus randomized frames, compared each
// cycle against a time-based reference model (digit = t/DIV mod N, position = t mod DIV).
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int BF    = 2;
  localparam int FRAME = N * DIV;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic [4*N-1:0] digits_in;
  logic           lzb_en;
  logic [N-1:0]   blink_mask;
  logic [3:0]     digit_bcd;
  logic [N-1:0]   digit_en_n;
  logic           frame_start;

  seg7_scan_ctrl #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in), .lzb_en(lzb_en),
    .blink_mask(blink_mask), .digit_bcd(digit_bcd), .digit_en_n(digit_en_n),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: cycles since the current run began, and the per-frame snapshot.
  bit          running     = 1'b0;
  int unsigned t_m         = 0;
  int unsigned frames_done = 0;
  logic [15:0] snap_d      = '0;
  bit          snap_lzb    = 1'b0;
  logic [N-1:0] snap_mask  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t_m);
  endtask

  task automatic take_snapshot();
    snap_d    = digits_in;
    snap_lzb  = lzb_en;
    snap_mask = blink_mask;
  endtask

  task automatic model_edge();
    if (!enable) begin
      running = 1'b0;
    end else if (!running) begin
      running = 1'b1;
      t_m     = 0;
      take_snapshot();
    end else begin
      t_m++;
      if (t_m % FRAME == 0) begin
        frames_done++;
        take_snapshot();
      end
    end
  endtask

  task automatic model_reset();
    running     = 1'b0;
    t_m         = 0;
    frames_done = 0;
  endtask

  task automatic tick(input string tag);
    logic [3:0]   e_bcd;
    logic [N-1:0] e_en;
    logic         e_fs;
    int           d, pos, hi;
    bit           blanked, phase;
    model_edge();
    @(posedge clk);
    #1;
    e_bcd = 4'hF;
    e_en  = '1;
    e_fs  = 1'b0;
    if (running) begin
      d   = (t_m / DIV) % N;
      pos = t_m % DIV;
      hi  = 0;
      for (int i = 0; i < N; i++) if (snap_d[4*i +: 4] != 4'h0) hi = i;
      phase = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
      phase = ((frames_done / BF) % 2) == 1;
`endif
      blanked = (snap_lzb && d > hi) || (phase && snap_mask[d]);
      e_fs    = (t_m % FRAME) == 0;
      if (!blanked) begin
        e_bcd = snap_d[4*d +: 4];
        if (pos >= BLK) e_en[d] = 1'b0;
      end
    end
    check({tag, ".bcd"}, 32'(digit_bcd), 32'(e_bcd));
    check({tag, ".en_n"}, 32'(digit_en_n), 32'(e_en));
    check({tag, ".fs"}, 32'(frame_start), 32'(e_fs));
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Advance until the model is in the driving part of digit d (bounded).
  task automatic run_to_drive(input int d, input string tag);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (running && (t_m / DIV) % N == d && t_m % DIV >= BLK + 1) break;
      tick(tag);
    end
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".bcd"}, 32'(digit_bcd), 32'h0000000F);
    check({tag, ".en_n"}, 32'(digit_en_n), 32'(4'b1111));
    check({tag, ".fs"}, 32'(frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b1;
    enable     = 1'b0;
    digits_in  = '0;
    lzb_en     = 1'b0;
    blink_mask = '0;
    #1;
    async_reset_check("reset");
    run(3, "idle");

    // Basic scan of 1234 over two frames, then a mid-frame change at digit 1.
    digits_in = 16'h1234;
    enable    = 1'b1;
    run(2 * FRAME, "scan1234");
    run_to_drive(1, "to_d1");
    digits_in = 16'h5678;
    run(FRAME + DIV, "midchange");

    // Leading-zero blanking.
    enable = 1'b0;
    tick("dis");
    digits_in = 16'h0007;
    lzb_en    = 1'b1;
    enable    = 1'b1;
    run(FRAME + 1, "lzb0007");
    enable = 1'b0;
    tick("dis");
    digits_in = 16'h0000;
    enable    = 1'b1;
    run(FRAME + 1, "lzb0000");

    // Non-decimal nibble passes through with its enable driven.
    enable = 1'b0;
    tick("dis");
    lzb_en    = 1'b0;
    digits_in = 16'h12A4;
    enable    = 1'b1;
    run(FRAME + 1, "hexA");

    // Enable drop while driving digit 2, then restart.
    run_to_drive(2, "to_d2");
    enable = 1'b0;
    run(2, "drop");
    enable = 1'b1;
    run(FRAME + 3, "restart");

    // Asynchronous reset in the middle of a driving slot.
    run_to_drive(1, "to_rst");
    #2;
    async_reset_check("midrst");
    run(DIV + 2, "after_rst");

    // Randomized frames with random mid-frame digit changes.
    for (int r = 0; r < 8; r++) begin
      enable = 1'b0;
      run($urandom_range(1, 2), "rnd_dis");
      digits_in  = 16'($urandom) >> (4 * $urandom_range(0, 3));
      lzb_en     = 1'($urandom_range(0, 1));
      blink_mask = N'($urandom);
      enable     = 1'b1;
      run($urandom_range(1, FRAME - 1), "rnd_a");
      digits_in = 16'($urandom);
      run(FRAME + $urandom_range(0, DIV), "rnd_b");
    end

`ifdef SEG_SCAN_BLINK_EN
    // Blink: frames 0-1 normal, 2-3 blink digits 1 and 0, frame 4 normal again.
    enable = 1'b0;
    @(negedge clk);
    async_reset_check("blink_rst");
    digits_in  = 16'h1234;
    lzb_en     = 1'b0;
    blink_mask = 4'b0011;
    enable     = 1'b1;
    run(5 * FRAME + 1, "blink");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
